mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Parametrised successor to the fixed-width convert-then-multiply Montgomery top.
- Sequences an external Montgomery multiplier core (mul = a*b*R^-1 mod n, R = 2^WIDTH) over a request/acknowledge handshake.
- Mode 0: single modular multiply x*y mod n. Mode 1: modular exponentiation x^e mod n, left-to-right square-and-multiply.
- Sits between the RSA datapath/host interface and the multiplier core.

Parameters:
- WIDTH, 2048, operand/modulus width in bits; R = 2^WIDTH.
- EXP_WIDTH, 2048, exponent register width in bits.
- LEN_W, 12, width of e_len; must hold EXP_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- mode  input  1  0 = modmul, 1 = modexp.
- x  input  WIDTH  base/multiplicand, normal domain, must be < n.
- y  input  WIDTH  multiplier for mode 0, must be < n.
- e  input  EXP_WIDTH  exponent for mode 1.
- e_len  input  LEN_W  number of significant exponent bits.
- r2  input  WIDTH  precomputed R^2 mod n.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when result is valid.
- error  output  1  valid with done; 1 = e_len > EXP_WIDTH.
- result  output  WIDTH  final value; held until next accepted start.
- mul_req  output  1  multiplier request; level held until mul_ack.
- mul_a  output  WIDTH  multiplier operand A.
- mul_b  output  WIDTH  multiplier operand B.
- mul_ack  input  1  multiplier completion pulse; mul_r valid this cycle.
- mul_r  input  WIDTH  multiplier result.

Behaviour:
- Reset (rst_n = 0 at a clock edge): state IDLE; busy, done, error, mul_req = 0; result, mul_a, mul_b, internal acc/xm/bit index = 0.
- Reset mid-operation aborts immediately. mul_req drops the next cycle. A later mul_ack is ignored.
- start, mode, x, y, e, e_len and r2 are registered on acceptance. Later input changes have no effect on the running operation.
- start while busy is ignored.
- Handshake:
  - mul_req rises together with stable mul_a/mul_b, and both stay constant while mul_req = 1.
  - On the first cycle with mul_req = 1 and mul_ack = 1, capture mul_r and drop mul_req.
  - The next request is issued no earlier than the following cycle.
  - mul_ack while mul_req = 0 is ignored.
- States:
  - IDLE: on start, if mode = 1 and e_len > EXP_WIDTH, go to DONE with error = 1 and result = 0. Otherwise go to CONV_X.
  - CONV_X: mul(x, r2) -> xm. Mode 0 goes to MULT_Y. Mode 1 goes to CONV_ONE.
  - MULT_Y: mul(xm, y) -> result (already normal domain). Go to DONE.
  - CONV_ONE: mul(1, r2) -> acc (R mod n). Set bit index i = e_len-1. If e_len = 0, go to CONV_OUT; otherwise go to SQUARE.
  - SQUARE: mul(acc, acc) -> acc. If e[i] = 1, go to MULT; otherwise go to NEXT.
  - MULT: mul(acc, xm) -> acc. Go to NEXT.
  - NEXT: if i = 0, go to CONV_OUT; else decrement i and go to SQUARE. This state is one idle cycle.
  - CONV_OUT: mul(acc, 1) -> result. Go to DONE.
  - DONE: done = 1 for exactly one cycle, busy = 0. Return to IDLE. start is accepted again from the next cycle.
- Multiplication count:
  - Mode 0: exactly 2.
  - Mode 1: 3 + e_len + popcount(e[e_len-1:0]).
  - e_len = 0 gives result 1.
- Leading zero bits below e_len are legal and only cost squarings.
- Arithmetic: the block performs no reduction of its own. Correctness relies on the core returning values < n.

Test Plan:
- Bench uses a behavioural multiplier model (mul_r = a*b*R^-1 mod n, ack latency L = 1 or 5). Config: WIDTH = 8, n = 13, r2 = 3.
- Mode 0, x = 5, y = 7 -> result = 9, done pulse once, exactly 2 requests, error = 0.
- Mode 1, x = 2, e = 0b1011, e_len = 4 -> result = 7, exactly 10 requests in the order CONV_X, CONV_ONE, S, M, S, S, M, S, M, CONV_OUT.
- Mode 1, e_len = 0 -> result = 1 after 3 requests. Mode 1, e_len = EXP_WIDTH+1 -> done with error = 1, result = 0, no request issued.
- Toggle start and x while busy -> ignored, result unchanged from the first operation. Inject a spurious mul_ack while mul_req = 0 -> no state change.
- Assert rst_n = 0 during SQUARE -> next cycle busy = 0, mul_req = 0. A late mul_ack is ignored. A new mode 0 run then completes correctly.

Source files
------------

// File: rtl/mont_exp_ctrl_if.sv
// Request/acknowledge bus between the Montgomery exponentiation
// controller (master) and an external Montgomery multiplier core (slave).
// The core returns mul_r = mul_a * mul_b * R^-1 mod n, with R = 2^WIDTH.
interface mont_exp_ctrl_if #(
   parameter int WIDTH = 2048
);

   logic             mul_req;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_ack;
   logic [WIDTH-1:0] mul_r;

   modport master (
      output mul_req,
      output mul_a,
      output mul_b,
      input  mul_ack,
      input  mul_r
   );

   modport slave (
      input  mul_req,
      input  mul_a,
      input  mul_b,
      output mul_ack,
      output mul_r
   );

endinterface

// File: rtl/mont_exp_ctrl.sv
// Montgomery exponentiation controller.
// Mode 0: result = x*y mod n      (convert x, then one multiply that leaves
//                                  the Montgomery domain by itself).
// Mode 1: result = x^e mod n      (left-to-right square-and-multiply over the
//                                  e_len low bits of e, in the Montgomery domain).
// All arithmetic is done by the external core; this block only sequences
// operands and never reduces anything itself.
module mont_exp_ctrl #(
   parameter int WIDTH     = 2048,
   parameter int EXP_WIDTH = 2048,
   parameter int LEN_W     = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic [EXP_WIDTH-1:0] e,
   input  logic [LEN_W-1:0]     e_len,
   input  logic [WIDTH-1:0]     r2,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [WIDTH-1:0]     result,
   mont_exp_ctrl_if.master      mul
);

   // Bit index only has to address e; e_len - 1 always fits once the
   // e_len > EXP_WIDTH case has been rejected at start.
   localparam int               IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam logic [LEN_W-1:0] EXP_MAX = LEN_W'(EXP_WIDTH);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_CONV_X   = 4'd1,
      ST_MULT_Y   = 4'd2,
      ST_CONV_ONE = 4'd3,
      ST_SQUARE   = 4'd4,
      ST_MULT     = 4'd5,
      ST_NEXT     = 4'd6,
      ST_CONV_OUT = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   state_t               state_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 error_r;
   logic [WIDTH-1:0]     result_r;
   logic                 mul_req_r;
   logic [WIDTH-1:0]     mul_a_r;
   logic [WIDTH-1:0]     mul_b_r;

   // Operation parameters captured at start so the host may change its
   // inputs freely while an operation runs.
   logic                 mode_r;
   logic [WIDTH-1:0]     x_r;
   logic [WIDTH-1:0]     y_r;
   logic [EXP_WIDTH-1:0] e_r;
   logic [LEN_W-1:0]     e_len_r;
   logic [WIDTH-1:0]     r2_r;

   // Montgomery-domain working values.
   logic [WIDTH-1:0]     acc_r;
   logic [WIDTH-1:0]     xm_r;
   logic [IDX_W-1:0]     idx_r;

   logic                 mul_state_s;
   logic [WIDTH-1:0]     op_a_s;
   logic [WIDTH-1:0]     op_b_s;
   logic                 fire_s;

   // Operand pair for whichever multiply the current state performs.
   always_comb begin
      mul_state_s = 1'b0;
      op_a_s      = ZERO;
      op_b_s      = ZERO;
      case (state_r)
         ST_CONV_X: begin
            mul_state_s = 1'b1;
            op_a_s      = x_r;
            op_b_s      = r2_r;
         end
         ST_MULT_Y: begin
            mul_state_s = 1'b1;
            op_a_s      = xm_r;
            op_b_s      = y_r;
         end
         ST_CONV_ONE: begin
            mul_state_s = 1'b1;
            op_a_s      = ONE;
            op_b_s      = r2_r;
         end
         ST_SQUARE: begin
            mul_state_s = 1'b1;
            op_a_s      = acc_r;
            op_b_s      = acc_r;
         end
         ST_MULT: begin
            mul_state_s = 1'b1;
            op_a_s      = acc_r;
            op_b_s      = xm_r;
         end
         ST_CONV_OUT: begin
            mul_state_s = 1'b1;
            op_a_s      = acc_r;
            op_b_s      = ONE;
         end
         default: begin
            mul_state_s = 1'b0;
            op_a_s      = ZERO;
            op_b_s      = ZERO;
         end
      endcase
   end

   // An acknowledge only counts while a request is outstanding.
   assign fire_s = mul_req_r & mul.mul_ack;

   // Sequencer: a multiply state raises its request on its first cycle
   // (request was low on entry), then waits for the acknowledge, captures
   // the product, drops the request and moves on. The next state can only
   // raise a new request one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         error_r   <= 1'b0;
         result_r  <= ZERO;
         mul_req_r <= 1'b0;
         mul_a_r   <= ZERO;
         mul_b_r   <= ZERO;
         mode_r    <= 1'b0;
         x_r       <= ZERO;
         y_r       <= ZERO;
         e_r       <= {EXP_WIDTH{1'b0}};
         e_len_r   <= {LEN_W{1'b0}};
         r2_r      <= ZERO;
         acc_r     <= ZERO;
         xm_r      <= ZERO;
         idx_r     <= {IDX_W{1'b0}};
      end else begin
         if (mul_state_s && !mul_req_r) begin
            mul_req_r <= 1'b1;
            mul_a_r   <= op_a_s;
            mul_b_r   <= op_b_s;
         end else if (fire_s) begin
            mul_req_r <= 1'b0;
         end

         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  mode_r  <= mode;
                  x_r     <= x;
                  y_r     <= y;
                  e_r     <= e;
                  e_len_r <= e_len;
                  r2_r    <= r2;
                  if (mode && (e_len > EXP_MAX)) begin
                     // Exponent length the register cannot hold: report
                     // straight away without touching the core.
                     state_r  <= ST_DONE;
                     busy_r   <= 1'b0;
                     done_r   <= 1'b1;
                     error_r  <= 1'b1;
                     result_r <= ZERO;
                  end else begin
                     state_r <= ST_CONV_X;
                     busy_r  <= 1'b1;
                     error_r <= 1'b0;
                  end
               end
            end
            ST_CONV_X: begin
               if (fire_s) begin
                  xm_r    <= mul.mul_r;
                  state_r <= mode_r ? ST_CONV_ONE : ST_MULT_Y;
               end
            end
            ST_MULT_Y: begin
               // xm * y * R^-1 = x * y: already back in the normal domain.
               if (fire_s) begin
                  result_r <= mul.mul_r;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= ST_DONE;
               end
            end
            ST_CONV_ONE: begin
               // 1 * R^2 * R^-1 = R mod n, the Montgomery form of 1.
               if (fire_s) begin
                  acc_r   <= mul.mul_r;
                  idx_r   <= IDX_W'(e_len_r - LEN_W'(1));
                  state_r <= (e_len_r == {LEN_W{1'b0}}) ? ST_CONV_OUT : ST_SQUARE;
               end
            end
            ST_SQUARE: begin
               if (fire_s) begin
                  acc_r   <= mul.mul_r;
                  state_r <= e_r[idx_r] ? ST_MULT : ST_NEXT;
               end
            end
            ST_MULT: begin
               if (fire_s) begin
                  acc_r   <= mul.mul_r;
                  state_r <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (idx_r == {IDX_W{1'b0}}) begin
                  state_r <= ST_CONV_OUT;
               end else begin
                  idx_r   <= idx_r - IDX_W'(1);
                  state_r <= ST_SQUARE;
               end
            end
            ST_CONV_OUT: begin
               // acc * 1 * R^-1 leaves the Montgomery domain.
               if (fire_s) begin
                  result_r <= mul.mul_r;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r   <= ST_IDLE;
               busy_r    <= 1'b0;
               done_r    <= 1'b0;
               mul_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign error       = error_r;
   assign result      = result_r;
   assign mul.mul_req = mul_req_r;
   assign mul.mul_a   = mul_a_r;
   assign mul.mul_b   = mul_b_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: WIDTH = 8, n = 13, R = 256, r2 = 3.
// A behavioural Montgomery core answers requests after a programmable
// latency; every request is checked against an expected operand queue and
// every done pulse against an expected result queue.
module tb_mont_exp_ctrl;

   localparam int W  = 8;
   localparam int EW = 8;
   localparam int LW = 4;
   localparam int N  = 13;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          mode;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic [EW-1:0] e;
   logic [LW-1:0] e_len;
   logic [W-1:0]  r2;
   logic          busy;
   logic          done;
   logic          error;
   logic [W-1:0]  result;

   logic          ack_s = 1'b0;
   logic [W-1:0]  mr_s  = 8'h00;

   mont_exp_ctrl_if #(.WIDTH(W)) mif ();

   assign mif.mul_ack = ack_s;
   assign mif.mul_r   = mr_s;

   mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .x      (x),
      .y      (y),
      .e      (e),
      .e_len  (e_len),
      .r2     (r2),
      .busy   (busy),
      .done   (done),
      .error  (error),
      .result (result),
      .mul    (mif)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int rinv    = 0;
   int r2v     = 0;

   logic [2*W-1:0] exp_req_q [$];
   logic [W:0]     exp_res_q [$];

   int   req_seen  = 0;
   int   done_cnt  = 0;
   int   lat       = 1;
   int   spur_req  = 0;
   int   spur_done = 0;
   bit   active    = 1'b0;
   int   cnt       = 0;
   logic [W-1:0]   lat_a;
   logic [W-1:0]   lat_b;
   logic [2*W-1:0] req_exp;
   logic [W:0]     res_exp;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [W-1:0] mm(input logic [W-1:0] a, input logic [W-1:0] b);
      int p;
      p = (int'(a) * int'(b) * rinv) % N;
      return W'(p);
   endfunction

   // Plain repeated multiplication in the normal domain.
   function automatic int powmod(input int b, input int ev);
      int r;
      r = 1 % N;
      for (int k = 0; k < ev; k++) r = (r * b) % N;
      return r;
   endfunction

   // Expected request sequence and result for one operation.
   task automatic expect_op(input logic m, input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input logic [EW-1:0] ev, input logic [LW-1:0] el, output int n);
      logic [W-1:0] xm;
      logic [W-1:0] acc;
      int res;
      n = 0;
      if (m && (int'(el) > EW)) begin
         exp_res_q.push_back({1'b1, 8'h00});
         return;
      end
      exp_req_q.push_back({xv, W'(r2v)});
      xm = mm(xv, W'(r2v));
      n++;
      if (!m) begin
         exp_req_q.push_back({xm, yv});
         n++;
         res = (int'(xv) * int'(yv)) % N;
      end else begin
         exp_req_q.push_back({8'h01, W'(r2v)});
         acc = mm(8'h01, W'(r2v));
         n++;
         for (int i = int'(el) - 1; i >= 0; i--) begin
            exp_req_q.push_back({acc, acc});
            acc = mm(acc, acc);
            n++;
            if (ev[i]) begin
               exp_req_q.push_back({acc, xm});
               acc = mm(acc, xm);
               n++;
            end
         end
         exp_req_q.push_back({acc, 8'h01});
         n++;
         res = powmod(int'(xv), int'(ev) & ((1 << int'(el)) - 1));
      end
      exp_res_q.push_back({1'b0, res[W-1:0]});
   endtask

   // Behavioural Montgomery core, driven on the falling edge.
   always @(negedge clk) begin
      if (ack_s) begin
         ack_s = 1'b0;
      end else if (active) begin
         cnt--;
         if (cnt <= 0) begin
            if (mif.mul_req) check_eq("op_stable", {mif.mul_a, mif.mul_b}, {lat_a, lat_b});
            mr_s   = mm(lat_a, lat_b);
            ack_s  = 1'b1;
            active = 1'b0;
         end
      end else if (spur_req != spur_done) begin
         spur_done++;
         mr_s  = 8'hA5;
         ack_s = 1'b1;
      end else if (mif.mul_req) begin
         active = 1'b1;
         cnt    = lat;
         lat_a  = mif.mul_a;
         lat_b  = mif.mul_b;
         req_seen++;
         if (exp_req_q.size() == 0) begin
            check_eq("req_extra", {mif.mul_a, mif.mul_b}, 32'hFFFF_FFFF);
         end else begin
            req_exp = exp_req_q.pop_front();
            check_eq("req_ops", {mif.mul_a, mif.mul_b}, req_exp);
         end
      end
   end

   // Result scoreboard.
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (exp_res_q.size() == 0) begin
            check_eq("done_extra", {error, result}, 32'hFFFF_FFFF);
         end else begin
            res_exp = exp_res_q.pop_front();
            check_eq("result", result, res_exp[W-1:0]);
            check_eq("error", error, res_exp[W]);
            check_eq("busy_at_done", busy, 1'b0);
         end
      end
   end

   task automatic run_op(input string tag, input logic m, input logic [W-1:0] xv,
                         input logic [W-1:0] yv, input logic [EW-1:0] ev,
                         input logic [LW-1:0] el, input int l, input bit poke);
      int n_req;
      int base_req;
      int base_done;
      bit got;
      bit err_exp;
      err_exp   = m && (int'(el) > EW);
      lat       = l;
      expect_op(m, xv, yv, ev, el, n_req);
      base_req  = req_seen;
      base_done = done_cnt;
      @(negedge clk);
      start = 1'b1; mode = m; x = xv; y = yv; e = ev; e_len = el; r2 = W'(r2v);
      @(negedge clk);
      start = 1'b0; mode = ~m; x = ~xv; y = ~yv; e = ~ev; e_len = ~el; r2 = ~W'(r2v);
      check_eq({tag, "_busy"}, busy, !err_exp);
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if (done_cnt != base_done) begin
            got = 1'b1;
            break;
         end
         if (poke && c == 8) begin
            @(negedge clk);
            start = 1'b1; mode = 1'b0; x = 8'h09;
            @(negedge clk);
            start = 1'b0;
         end
      end
      #1;
      check_eq({tag, "_done_seen"}, got, 1'b1);
      check_eq({tag, "_done_pulse"}, done, 1'b0);
      check_eq({tag, "_busy_end"}, busy, 1'b0);
      check_eq({tag, "_nreq"}, req_seen - base_req, n_req);
      check_eq({tag, "_req_left"}, exp_req_q.size(), 0);
   endtask

   initial begin
      int  n_dummy;
      int  base_req;
      int  base_done;
      bit  got;

      for (int k = 1; k < N; k++) if (((1 << W) * k) % N == 1) rinv = k;
      r2v = ((1 << W) * (1 << W)) % N;

      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      x = 8'h00; y = 8'h00; e = 8'h00; e_len = 4'h0; r2 = W'(r2v);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_error", error, 1'b0);
      check_eq("rst_result", result, 8'h00);
      check_eq("rst_req", mif.mul_req, 1'b0);
      check_eq("rst_mul_ab", {mif.mul_a, mif.mul_b}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul57", 1'b0, 8'd5, 8'd7, 8'h00, 4'd0, 1, 1'b0);

      base_done = done_cnt;
      spur_req++;
      repeat (4) @(posedge clk);
      #1;
      check_eq("spur_req", mif.mul_req, 1'b0);
      check_eq("spur_busy", busy, 1'b0);
      check_eq("spur_done", done_cnt - base_done, 0);
      check_eq("spur_result", result, 8'd9);

      run_op("mul57_l5", 1'b0, 8'd5, 8'd7, 8'h00, 4'd0, 5, 1'b0);
      run_op("exp1011", 1'b1, 8'd2, 8'd0, 8'b0000_1011, 4'd4, 1, 1'b0);
      run_op("exp_poke", 1'b1, 8'd2, 8'd0, 8'b0000_1011, 4'd4, 5, 1'b1);
      run_op("exp_len0", 1'b1, 8'd5, 8'd0, 8'hFF, 4'd0, 5, 1'b0);
      run_op("exp_err", 1'b1, 8'd5, 8'd0, 8'h0B, 4'd9, 1, 1'b0);
      run_op("exp_full", 1'b1, 8'd7, 8'd0, 8'b0010_0110, 4'd8, 1, 1'b0);
      run_op("mul_edge", 1'b0, 8'd12, 8'd12, 8'h00, 4'd0, 1, 1'b0);

      // Abort during SQUARE, then let the core's late acknowledge arrive.
      lat = 5;
      expect_op(1'b1, 8'd2, 8'd0, 8'b0000_1011, 4'd4, n_dummy);
      base_req  = req_seen;
      base_done = done_cnt;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; x = 8'd2; e = 8'b0000_1011; e_len = 4'd4; r2 = W'(r2v);
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk);
         if (req_seen >= base_req + 3) begin
            got = 1'b1;
            break;
         end
      end
      check_eq("rst_reach_square", got, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_req", mif.mul_req, 1'b0);
      check_eq("abort_mul_a", mif.mul_a, 8'h00);
      check_eq("abort_result", result, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_eq("late_ack_req", mif.mul_req, 1'b0);
      check_eq("late_ack_busy", busy, 1'b0);
      check_eq("late_ack_nreq", req_seen - base_req, 3);
      check_eq("late_ack_done", done_cnt - base_done, 0);
      exp_req_q.delete();
      exp_res_q.delete();

      run_op("mul_after_rst", 1'b0, 8'd5, 8'd7, 8'h00, 4'd0, 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
